// File: rtl/ps2_uart_streamer.sv
// PS/2 mouse record FIFO streamed out as UART 8N1 packets (header, addr, data).
// Define PS2_STREAM_CHECKSUM_EN to append an XOR checksum byte to each packet.
module ps2_uart_streamer #(
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter logic [7:0]  HDR_BYTE     = 8'hA5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        dav,
  input  logic [DATA_W-1:0]           data_in,
  input  logic [1:0]                  addr,
  input  logic                        clr_ovf,
  output logic                        txd,
  output logic                        busy,
  output logic                        pkt_done,
  output logic                        ovf,
  output logic [$clog2(FIFO_DEPTH):0] level
);

  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned LW  = AW + 1;
  localparam int unsigned RW  = DATA_W + 2;
  localparam int unsigned NDB = DATA_W / 8;
`ifdef PS2_STREAM_CHECKSUM_EN
  localparam int unsigned NB  = NDB + 3;
`else
  localparam int unsigned NB  = NDB + 2;
`endif
  localparam int unsigned BW  = $clog2(NB);
  localparam int unsigned CW  = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [BW-1:0] byte_q, byte_d;
  logic [7:0]    sh_q, sh_d;
  logic [RW-1:0] rec_q, rec_d;
  logic          txd_q, txd_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          ovf_q, ovf_d;
  logic [LW-1:0] lvl_q, lvl_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
`ifdef PS2_STREAM_CHECKSUM_EN
  logic [7:0]    csum_q, csum_d;
`endif

  logic [RW-1:0] mem_q [FIFO_DEPTH];

  logic          full, empty, tick, last;
  logic          push, pop;
  logic [BW-1:0] idx_n;
  logic [7:0]    nxt_byte;

  assign full  = lvl_q == LW'(FIFO_DEPTH);
  assign empty = lvl_q == '0;
  assign tick  = cnt_q == CW'(CLKS_PER_BIT - 1);
  assign last  = byte_q == BW'(NB - 1);
  assign push  = dav & ~full;
  // Pop either from idle or straight out of the final stop bit (back-to-back).
  assign pop   = ~empty & ((state_q == IDLE) |
                 ((state_q == STOP) & tick & last));
  assign idx_n = byte_q + 1'b1;

  always_comb begin
    nxt_byte = HDR_BYTE;
    if (idx_n == BW'(1)) nxt_byte = {6'b0, rec_q[RW-1 -: 2]};
    for (int j = 0; j < NDB; j++) begin
      if (idx_n == BW'(j + 2)) nxt_byte = rec_q[DATA_W-1-8*j -: 8];
    end
`ifdef PS2_STREAM_CHECKSUM_EN
    if (idx_n == BW'(NB - 1)) nxt_byte = csum_q;
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = (state_q == IDLE || tick) ? '0 : cnt_q + 1'b1;
    bit_d   = bit_q;
    byte_d  = byte_q;
    sh_d    = sh_q;
    rec_d   = rec_q;
    txd_d   = txd_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    wr_d    = push ? wr_q + 1'b1 : wr_q;
    rd_d    = rd_q;
    lvl_d   = lvl_q + LW'(push) - LW'(pop);
    ovf_d   = (dav & full) ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);
`ifdef PS2_STREAM_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    unique case (state_q)
      IDLE: begin
        txd_d  = 1'b1;
        busy_d = 1'b0;
      end
      START: if (tick) begin
        state_d = DATA;
        bit_d   = '0;
        txd_d   = sh_q[0];
      end
      DATA: if (tick) begin
        if (bit_q == 3'd7) begin
          state_d = STOP;
          txd_d   = 1'b1;
        end else begin
          bit_d = bit_q + 3'd1;
          sh_d  = {1'b0, sh_q[7:1]};
          txd_d = sh_q[1];
        end
      end
      STOP: if (tick) begin
        if (last) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = START;
          txd_d   = 1'b0;
          byte_d  = idx_n;
          sh_d    = nxt_byte;
`ifdef PS2_STREAM_CHECKSUM_EN
          csum_d  = csum_q ^ nxt_byte;
`endif
        end
      end
    endcase
    if (pop) begin
      state_d = START;
      txd_d   = 1'b0;
      busy_d  = 1'b1;
      byte_d  = '0;
      sh_d    = HDR_BYTE;
      rec_d   = mem_q[rd_q];
      rd_d    = rd_q + 1'b1;
`ifdef PS2_STREAM_CHECKSUM_EN
      csum_d  = HDR_BYTE;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= {addr, data_in};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      sh_q    <= '0;
      rec_q   <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      lvl_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
`ifdef PS2_STREAM_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      sh_q    <= sh_d;
      rec_q   <= rec_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      lvl_q   <= lvl_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
`ifdef PS2_STREAM_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign txd      = txd_q;
  assign busy     = busy_q;
  assign pkt_done = done_q;
  assign ovf      = ovf_q;
  assign level    = lvl_q;

endmodule

// File: doc/ps2_uart_streamer.md
PS2_UART_STREAMER -- requirements
Module: ps2_uart_streamer

Interface
REQ-001 SHALL have parameter DATA_W, default 16, width of the mouse data word; a nonzero multiple of 8.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, number of buffered records; a power of 2, at least 2.
REQ-003 SHALL have parameter CLKS_PER_BIT, default 434, clocks per UART bit; at least 4.
REQ-004 SHALL have parameter HDR_BYTE, default 8'hA5, packet header byte.
REQ-005 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port dav, input, 1 bit: single-cycle strobe; data_in and addr are valid in that cycle.
REQ-008 SHALL have port data_in, input, DATA_W bits: mouse data word.
REQ-009 SHALL have port addr, input, 2 bits: mouse register address tagging data_in.
REQ-010 SHALL have port clr_ovf, input, 1 bit: clears the overflow flag.
REQ-011 SHALL have port txd, output, 1 bit: UART serial out, 8N1, idle high.
REQ-012 SHALL have port busy, output, 1 bit: high while a packet is being shifted out.
REQ-013 SHALL have port pkt_done, output, 1 bit: one-cycle pulse at the end of a packet's final stop bit.
REQ-014 SHALL have port ovf, output, 1 bit: sticky flag, set when a record is dropped.
REQ-015 SHALL have port level, output, clog2(FIFO_DEPTH)+1 bits: current FIFO occupancy.

Function
REQ-016 SHALL, on each dav, push the record {addr, data_in} into the FIFO when level < FIFO_DEPTH.
REQ-017 SHALL drop a dav arriving while level == FIFO_DEPTH, even if a pop occurs in the same cycle, and set ovf.
REQ-018 SHALL, when dav and a pop coincide with level < FIFO_DEPTH, leave level unchanged.
REQ-019 SHALL build each packet as HDR_BYTE, then {6'b0, addr}, then DATA_W/8 data bytes MSB-first, then the checksum byte only under REQ-029.
REQ-020 SHALL send every byte as: start bit 0, eight data bits LSB-first, stop bit 1, each bit lasting exactly CLKS_PER_BIT clocks.
REQ-021 SHALL implement the FSM states IDLE, START, DATA, STOP:
- IDLE to START when the FIFO is non-empty; the pop and the byte load happen in that cycle.
- START to DATA after one bit time.
- DATA to STOP after 8 bits.
- STOP to START when packet bytes remain.
- STOP to IDLE after the last byte, with pkt_done pulsed in that cycle.
REQ-022 SHALL have a latency of 2 clocks from dav in cycle N (FIFO empty, IDLE) to txd falling to the start bit at the edge after cycle N+1.
REQ-023 SHALL send queued packets back-to-back: the next START immediately follows STOP, with no idle bit inserted.
REQ-024 SHALL hold busy high from the pop until the cycle after pkt_done.
REQ-025 SHALL clear ovf on clr_ovf; when a drop and clr_ovf coincide, ovf stays set (set wins).
REQ-026 SHALL wrap FIFO pointers modulo FIFO_DEPTH, with no record lost or duplicated across wrap.

Reset
REQ-027 SHALL, while rst is low, immediately force:
- txd = 1
- busy = 0
- pkt_done = 0
- ovf = 0
- level = 0
- FSM = IDLE
- bit/byte/baud counters = 0
- FIFO pointers = 0
REQ-028 SHALL abort a packet in progress on mid-packet reset, with txd returning high asynchronously; no partial packet resumes after reset deasserts.

Configuration
REQ-029 SHALL, with macro PS2_STREAM_CHECKSUM_EN defined, append one checksum byte equal to the XOR of every preceding byte of the packet, header included.
REQ-030 SHALL, without PS2_STREAM_CHECKSUM_EN, contain no checksum logic, and the packet ends after the last data byte.

Verification
REQ-031 SHALL cover the single-record case:
- Stimulus: CLKS_PER_BIT=4, DATA_W=16, dav with addr=2'b01, data_in=16'h12F0.
- Required response: txd serialises A5, 01, 12, F0 (plus checksum 46 when the macro is enabled); pkt_done fires 4*10*4=160 clocks after the start bit (200 clocks with the macro enabled).
REQ-032 SHALL cover overflow:
- Stimulus: FIFO_DEPTH=4, six dav strobes on consecutive cycles while idle.
- Required response: the first record pops at once; four are queued; the sixth is dropped; ovf=1; level peaks at 4.
REQ-033 SHALL cover clr_ovf:
- Stimulus: clr_ovf pulsed alone, then clr_ovf coincident with a dropped dav.
- Required response: ovf=0, then ovf=1.
REQ-034 SHALL cover reset mid-packet:
- Stimulus: rst low during the DATA bit 3 of the data byte, with 2 records queued.
- Required response: txd=1 and level=0 immediately; nothing is transmitted after release until a new dav.
REQ-035 SHALL cover pointer wrap:
- Stimulus: 10 records of data_in = 0x0000 through 0x0009, spaced so the FIFO never fills.
- Required response: all 10 packets are received in order, intact, with 10 pkt_done pulses.
